// File: rtl/hazard_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared encodings and defaults for the decode-stage stall controller.
//   - Tuse/Tnew are 2-bit cycle counts; TUSE_NONE marks an unused source.
//   - Default mult/div occupancy windows.
//   - src_hazard(): RAW check of one D-stage source against the E and M
//     destination registers.
// ----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // A source stalls when a pending producer will not have its result ready
    // by the time the D instruction consumes it. TUSE_NONE (3) can never be
    // below a 2-bit Tnew, so unused sources drop out naturally.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        logic w_e_hit;
        logic w_m_hit;
        w_e_hit = (src == e_wa) && (tuse < e_tnew);
        w_m_hit = (src == m_wa) && (tuse < m_tnew);
        return (src != REG_ZERO) && (w_e_hit || w_m_hit);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_md_busy_timer
//   Tracks the multiply/divide unit occupancy window. A start loads the
//   operation latency; the counter then counts down to zero.
//   Ports:
//     i_clk       rising-edge clock
//     i_reset     asynchronous active-low reset
//     i_md_start  mult/div issues this cycle
//     i_md_is_div 1 = div, 0 = mult (qualifies i_md_start)
//     o_md_busy   unit occupied (counter nonzero)
// ----------------------------------------------------------------------------
module hazard_stall_ctrl_md_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_md_start,
    input  logic i_md_is_div,
    output logic o_md_busy
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned BW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [BW-1:0] r_count;

    // A start while already busy simply reloads; the pipeline never issues one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_md_start) begin
            r_count <= i_md_is_div ? BW'(DIV_LAT) : BW'(MULT_LAT);
        end else if (r_count != '0) begin
            r_count <= r_count - BW'(1);
        end
    end

    assign o_md_busy = (r_count != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Decode-stage stall/redirect controller for the 5-stage pipeline.
//   Compares D-stage Tuse against E/M-stage Tnew, tracks the mult/div busy
//   window, and drives PC/IF-ID enables, the ID/EX bubble and the redirect.
//   Ports:
//     i_clk, i_reset           clock, asynchronous active-low reset
//     i_d_rs/rt, i_d_tuse_*    D-stage sources and their Tuse
//     i_d_is_md                D instr touches HI/LO or starts mult/div
//     i_d_br_valid/target      D-stage taken redirect
//     i_e_wa/tnew, i_m_wa/tnew E/M destination and Tnew
//     i_md_start, i_md_is_div  E-stage mult/div issue
//     o_pc_en, o_fd_en         PC and IF/ID enables
//     o_de_flush               bubble into ID/EX
//     o_npc_valid, o_npc       gated redirect
//     o_md_busy                mult/div unit occupied
//     o_stall_cnt              saturating count of stalled cycles
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_d_rs,
    input  logic [4:0]       i_d_rt,
    input  logic [1:0]       i_d_tuse_rs,
    input  logic [1:0]       i_d_tuse_rt,
    input  logic             i_d_is_md,
    input  logic             i_d_br_valid,
    input  logic [31:0]      i_d_br_target,
    input  logic [4:0]       i_e_wa,
    input  logic [1:0]       i_e_tnew,
    input  logic [4:0]       i_m_wa,
    input  logic [1:0]       i_m_tnew,
    input  logic             i_md_start,
    input  logic             i_md_is_div,
    output logic             o_pc_en,
    output logic             o_fd_en,
    output logic             o_de_flush,
    output logic             o_npc_valid,
    output logic [31:0]      o_npc,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic             w_rs_haz;
    logic             w_rt_haz;
    logic             w_md_haz;
    logic             w_stall;
    logic             w_md_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    hazard_stall_ctrl_md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_md_start  (i_md_start),
        .i_md_is_div (i_md_is_div),
        .o_md_busy   (w_md_busy)
    );

    assign w_rs_haz = src_hazard(i_d_rs, i_d_tuse_rs, i_e_wa, i_e_tnew, i_m_wa, i_m_tnew);
    assign w_rt_haz = src_hazard(i_d_rt, i_d_tuse_rt, i_e_wa, i_e_tnew, i_m_wa, i_m_tnew);
    // md_start covers the issue cycle, before the busy counter has loaded.
    assign w_md_haz = i_d_is_md && (w_md_busy || i_md_start);
    assign w_stall  = w_rs_haz || w_rt_haz || w_md_haz;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Redirect is suppressed while stalled; the branch re-resolves on release.
    assign o_pc_en     = !w_stall;
    assign o_fd_en     = !w_stall;
    assign o_de_flush  = w_stall;
    assign o_npc_valid = i_d_br_valid && !w_stall;
    assign o_npc       = i_d_br_target;
    assign o_md_busy   = w_md_busy;
    assign o_stall_cnt = r_stall_cnt;

endmodule
